// File: rtl/harzbus_slot_bridge.sv
`default_nettype none
// ============================================================================
// Module   : harzbus_slot_bridge
// Purpose  : HarzMMU request-bus responder; runs each request as a strobed
//            slot-bus cycle. Optional `HARZBUS_TIMEOUT_EN` aborts stuck waits.
// Revision : 1.0
// ============================================================================
module harzbus_slot_bridge #(
    parameter int SETUP_CYCLES   = 1,
    parameter int STROBE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  h_request,
    input  logic [15:0] h_address,
    input  logic [7:0]  h_write_data,
    output logic [7:0]  h_read_data,
    output logic        h_busy,
    output logic        slot_clock,
    output logic        slot_reset_n,
    output logic        slot_iorq,
    output logic        slot_merq,
    output logic        slot_rd,
    output logic        slot_wr,
    output logic [15:0] slot_a,
    output logic [7:0]  slot_write_d,
    input  logic [7:0]  slot_read_d,
    input  logic        slot_busy
`ifdef HARZBUS_TIMEOUT_EN
    ,
    output logic        timeout_flag
`endif
);

    localparam logic [3:0] REQ_IO_WRITE  = 4'd1;
    localparam logic [3:0] REQ_IO_READ   = 4'd2;
    localparam logic [3:0] REQ_MEM_WRITE = 4'd3;
    localparam logic [3:0] REQ_MEM_READ  = 4'd4;

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    generate
        if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 ||
            STROBE_CYCLES < 1 || STROBE_CYCLES > 15 ||
            TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_params
            $error("harzbus_slot_bridge: parameter out of range");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        ARM    = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        is_read, is_read_nx;
    logic [7:0]  hold_data, hold_nx;
    logic        busy_nx, iorq_nx, merq_nx, rd_nx, wr_nx;
    logic [15:0] a_nx;
    logic [7:0]  wd_nx, rdata_nx;
    logic        req_valid;
    logic        req_is_io;
    logic        req_is_read;

`ifdef HARZBUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES);
    logic [7:0] wait_cnt, wait_nx;
    logic       tflag_nx;
`endif

    assign slot_clock  = clk;
    assign req_valid   = (h_request >= REQ_IO_WRITE) && (h_request <= REQ_MEM_READ);
    assign req_is_io   = (h_request == REQ_IO_WRITE) || (h_request == REQ_IO_READ);
    assign req_is_read = (h_request == REQ_IO_READ) || (h_request == REQ_MEM_READ);

    always_ff @(posedge clk) begin
        slot_reset_n <= ~reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            is_read      <= 1'b0;
            hold_data    <= 8'h00;
            h_busy       <= 1'b0;
            h_read_data  <= 8'h00;
            slot_iorq    <= 1'b0;
            slot_merq    <= 1'b0;
            slot_rd      <= 1'b0;
            slot_wr      <= 1'b0;
            slot_a       <= 16'h0000;
            slot_write_d <= 8'h00;
`ifdef HARZBUS_TIMEOUT_EN
            wait_cnt     <= 8'd0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            is_read      <= is_read_nx;
            hold_data    <= hold_nx;
            h_busy       <= busy_nx;
            h_read_data  <= rdata_nx;
            slot_iorq    <= iorq_nx;
            slot_merq    <= merq_nx;
            slot_rd      <= rd_nx;
            slot_wr      <= wr_nx;
            slot_a       <= a_nx;
            slot_write_d <= wd_nx;
`ifdef HARZBUS_TIMEOUT_EN
            wait_cnt     <= wait_nx;
            timeout_flag <= tflag_nx;
`endif
        end
    end

    // Every slot output is computed here one cycle ahead and then registered,
    // so nothing on the h_* side reaches the slot pins combinationally.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        is_read_nx = is_read;
        hold_nx    = hold_data;
        busy_nx    = h_busy;
        rdata_nx   = h_read_data;
        iorq_nx    = slot_iorq;
        merq_nx    = slot_merq;
        rd_nx      = slot_rd;
        wr_nx      = slot_wr;
        a_nx       = slot_a;
        wd_nx      = slot_write_d;
`ifdef HARZBUS_TIMEOUT_EN
        wait_nx    = wait_cnt;
        tflag_nx   = timeout_flag;
`endif
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx   = SETUP;
                    cnt_nx     = 4'd0;
                    busy_nx    = 1'b1;
                    is_read_nx = req_is_read;
                    iorq_nx    = req_is_io;
                    merq_nx    = ~req_is_io;
                    a_nx       = h_address;
                    wd_nx      = h_write_data;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_nx = STROBE;
                    cnt_nx   = 4'd0;
                    rd_nx    = is_read;
                    wr_nx    = ~is_read;
`ifdef HARZBUS_TIMEOUT_EN
                    wait_nx  = 8'd0;
`endif
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            STROBE: begin
                // slot_busy only matters once the minimum width has elapsed.
                if (cnt != STROBE_LAST) begin
                    cnt_nx = cnt + 4'd1;
                end else if (!slot_busy) begin
                    state_nx = HOLD;
                    rd_nx    = 1'b0;
                    wr_nx    = 1'b0;
                    if (is_read) hold_nx = slot_read_d;
                end
`ifdef HARZBUS_TIMEOUT_EN
                else if (wait_cnt == TIMEOUT_LAST) begin
                    state_nx = HOLD;
                    rd_nx    = 1'b0;
                    wr_nx    = 1'b0;
                    tflag_nx = 1'b1;
                    if (is_read) hold_nx = 8'hFF;
                end else begin
                    wait_nx = wait_cnt + 8'd1;
                end
`endif
            end
            HOLD: begin
                state_nx = ARM;
                iorq_nx  = 1'b0;
                merq_nx  = 1'b0;
                busy_nx  = 1'b0;
                if (is_read) rdata_nx = hold_data;
            end
            ARM: begin
                // Wait for the client to drop its request so a held code runs once.
                if (h_request == 4'd0) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
